// File: rtl/tomasulo_pkg.sv
// Shared Tomasulo core constants: bus widths, requester count and the fixed
// requester index assignment seen by the common data bus arbiter.
package tomasulo_pkg;

   localparam int N_REQ  = 7;
   localparam int TAG_W  = 4;
   localparam int DATA_W = 32;
   localparam int SRC_W  = $clog2(N_REQ);

   // Requester index order on the arbiter: adders, then multipliers, then load ports
   localparam int SRC_ADD1 = 0;
   localparam int SRC_ADD2 = 1;
   localparam int SRC_ADD3 = 2;
   localparam int SRC_MUL1 = 3;
   localparam int SRC_MUL2 = 4;
   localparam int SRC_MEM1 = 5;
   localparam int SRC_MEM2 = 6;

endpackage

// File: rtl/rr_pick.sv
// Purely combinational round-robin picker: rotate the request vector so the
// pointer sits at bit 0, find the first set bit, then rotate the index back.
module rr_pick #(
   parameter int N  = 7,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] winner,
   output logic          any_valid
);

   logic [N-1:0] rotated;
   logic         found;
   int           first_j;
   int           idx;
   int           win;

   always_comb begin
      rotated = '0;
      found   = 1'b0;
      first_j = 0;
      idx     = 0;
      win     = 0;
      grant   = '0;
      for (int j = 0; j < N; j++) begin
         idx = int'(ptr) + j;
         if (idx >= N) idx = idx - N;
         rotated[j] = req[idx];
      end
      for (int j = 0; j < N; j++) begin
         if (!found && rotated[j]) begin
            found   = 1'b1;
            first_j = j;
         end
      end
      win = int'(ptr) + first_j;
      if (win >= N) win = win - N;
      if (found) grant[win] = 1'b1;
      winner    = IW'(win);
      any_valid = found;
   end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: picks one producer per cycle round-robin and drives
// the registered CDB broadcast snooped by reservation stations and the RST.
module cdb_arbiter #(
   parameter int N_REQ  = tomasulo_pkg::N_REQ,
   parameter int TAG_W  = tomasulo_pkg::TAG_W,
   parameter int DATA_W = tomasulo_pkg::DATA_W
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [N_REQ-1:0]          req_valid,
   input  logic [N_REQ*TAG_W-1:0]    req_tag,
   input  logic [N_REQ*DATA_W-1:0]   req_data,
   input  logic                      cdb_stall,
   output logic [N_REQ-1:0]          grant,
   output logic                      cdb_valid,
   output logic [TAG_W-1:0]          cdb_tag,
   output logic [DATA_W-1:0]         cdb_data,
   output logic [$clog2(N_REQ)-1:0]  cdb_src
);
   import tomasulo_pkg::*;

   localparam int SW = $clog2(N_REQ);

   logic [SW-1:0]     rr_ptr;
   logic [N_REQ-1:0]  pick_grant;
   logic [SW-1:0]     pick_winner;
   logic              pick_any;
   logic              fire;
   logic [TAG_W-1:0]  sel_tag;
   logic [DATA_W-1:0] sel_data;
   logic [SW-1:0]     next_ptr;

   rr_pick #(.N(N_REQ), .IW(SW)) u_pick (
      .req       (req_valid),
      .ptr       (rr_ptr),
      .grant     (pick_grant),
      .winner    (pick_winner),
      .any_valid (pick_any)
   );

   // Reset gates grant combinationally so a pending grant vanishes with it
   always_comb begin
      grant = '0;
      if (pick_any && !cdb_stall && !reset) grant = pick_grant;
   end

   assign fire     = |grant;
   assign next_ptr = (pick_winner == SW'(N_REQ - 1)) ? '0 : pick_winner + SW'(1);

   always_comb begin
      sel_tag  = '0;
      sel_data = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (pick_winner == SW'(i)) begin
            sel_tag  = req_tag[i*TAG_W +: TAG_W];
            sel_data = req_data[i*DATA_W +: DATA_W];
         end
      end
   end

   // Tag, data and source hold between broadcasts; only valid drops when idle
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rr_ptr    <= '0;
         cdb_valid <= 1'b0;
         cdb_tag   <= '0;
         cdb_data  <= '0;
         cdb_src   <= '0;
      end else if (fire) begin
         rr_ptr    <= next_ptr;
         cdb_valid <= 1'b1;
         cdb_tag   <= sel_tag;
         cdb_data  <= sel_data;
         cdb_src   <= pick_winner;
      end else begin
         cdb_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed vector table, reset corner
// sequence, and randomized traffic against a behavioural round-robin model.
module tb_cdb_arbiter;
   import tomasulo_pkg::*;

   localparam int SW = $clog2(N_REQ);

   logic                     clk = 1'b0;
   logic                     reset;
   logic [N_REQ-1:0]         req_valid;
   logic [N_REQ*TAG_W-1:0]   req_tag;
   logic [N_REQ*DATA_W-1:0]  req_data;
   logic                     cdb_stall;
   logic [N_REQ-1:0]         grant;
   logic                     cdb_valid;
   logic [TAG_W-1:0]         cdb_tag;
   logic [DATA_W-1:0]        cdb_data;
   logic [SW-1:0]            cdb_src;

   int n_compared = 0;
   int n_failed   = 0;

   typedef struct {
      logic [N_REQ-1:0]  valid;
      logic              stall;
      logic [TAG_W-1:0]  tag_base;
      logic [DATA_W-1:0] data_base;
      logic [N_REQ-1:0]  exp_grant;
      logic              exp_valid;
      logic [TAG_W-1:0]  exp_tag;
      logic [DATA_W-1:0] exp_data;
      logic [SW-1:0]     exp_src;
   } vec_t;

   vec_t vecs[$];

   cdb_arbiter dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_tag   (req_tag),
      .req_data  (req_data),
      .cdb_stall (cdb_stall),
      .grant     (grant),
      .cdb_valid (cdb_valid),
      .cdb_tag   (cdb_tag),
      .cdb_data  (cdb_data),
      .cdb_src   (cdb_src)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      n_compared++;
      if (actual !== expected) begin
         n_failed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Requester i presents tag_base+i and data_base+i so the winner is visible in the payload
   task automatic applyStimulus(input logic [N_REQ-1:0] valid, input logic stall,
                                input logic [TAG_W-1:0] tag_base, input logic [DATA_W-1:0] data_base);
      @(negedge clk);
      req_valid = valid;
      cdb_stall = stall;
      for (int i = 0; i < N_REQ; i++) begin
         req_tag[i*TAG_W +: TAG_W]    = tag_base + TAG_W'(i);
         req_data[i*DATA_W +: DATA_W] = data_base + DATA_W'(i);
      end
      #1;
   endtask

   // Behavioural reference state
   int                m_ptr;
   logic              m_valid;
   logic [TAG_W-1:0]  m_tag;
   logic [DATA_W-1:0] m_data;
   int                m_src;
   logic [TAG_W-1:0]  r_tags [N_REQ];
   logic [DATA_W-1:0] r_datas[N_REQ];

   initial begin
      vec_t v;
      int   g;
      int   w;
      logic [N_REQ-1:0] exp_g;

      reset     = 1'b1;
      req_valid = '0;
      req_tag   = '0;
      req_data  = '0;
      cdb_stall = 1'b0;

      #2;
      checkOutput("reset_grant", 32'(grant), 32'd0);
      checkOutput("reset_valid", 32'(cdb_valid), 32'd0);
      checkOutput("reset_tag", 32'(cdb_tag), 32'd0);
      checkOutput("reset_data", cdb_data, 32'd0);
      checkOutput("reset_src", 32'(cdb_src), 32'd0);
      @(negedge clk);
      reset = 1'b0;

      for (int k = 0; k < 8; k++) begin
         g = k % N_REQ;
         vecs.push_back('{7'h7F, 1'b0, 4'h0, 32'h100, 7'(1 << g), 1'b1, 4'(g), 32'h100 + 32'(g), 3'(g)});
      end
      vecs.push_back('{7'h00, 1'b0, 4'h0, 32'h0,    7'h00, 1'b0, 4'h0, 32'h0,    3'd0});
      vecs.push_back('{7'h04, 1'b0, 4'h3, 32'h1232, 7'h04, 1'b1, 4'h5, 32'h1234, 3'd2});
      vecs.push_back('{7'h00, 1'b0, 4'h0, 32'h0,    7'h00, 1'b0, 4'h0, 32'h0,    3'd0});
      vecs.push_back('{7'h20, 1'b0, 4'h1, 32'h2000, 7'h20, 1'b1, 4'h6, 32'h2005, 3'd5});
      vecs.push_back('{7'h41, 1'b0, 4'h1, 32'h2000, 7'h40, 1'b1, 4'h7, 32'h2006, 3'd6});
      vecs.push_back('{7'h01, 1'b0, 4'h1, 32'h2000, 7'h01, 1'b1, 4'h1, 32'h2000, 3'd0});
      for (int k = 0; k < 3; k++)
         vecs.push_back('{7'h0A, 1'b1, 4'h8, 32'h3000, 7'h00, 1'b0, 4'h0, 32'h0, 3'd0});
      vecs.push_back('{7'h0A, 1'b0, 4'h8, 32'h3000, 7'h02, 1'b1, 4'h9, 32'h3001, 3'd1});
      vecs.push_back('{7'h08, 1'b0, 4'h8, 32'h3000, 7'h08, 1'b1, 4'hB, 32'h3003, 3'd3});
      vecs.push_back('{7'h10, 1'b0, 4'h5, 32'h4000, 7'h10, 1'b1, 4'h9, 32'h4004, 3'd4});
      vecs.push_back('{7'h10, 1'b0, 4'h6, 32'h4100, 7'h10, 1'b1, 4'hA, 32'h4104, 3'd4});
      vecs.push_back('{7'h00, 1'b0, 4'h0, 32'h0,    7'h00, 1'b0, 4'h0, 32'h0,    3'd0});

      foreach (vecs[n]) begin
         v = vecs[n];
         applyStimulus(v.valid, v.stall, v.tag_base, v.data_base);
         checkOutput($sformatf("vec%0d_grant", n), 32'(grant), 32'(v.exp_grant));
         @(posedge clk);
         #1;
         checkOutput($sformatf("vec%0d_valid", n), 32'(cdb_valid), 32'(v.exp_valid));
         if (v.exp_valid) begin
            checkOutput($sformatf("vec%0d_tag", n), 32'(cdb_tag), 32'(v.exp_tag));
            checkOutput($sformatf("vec%0d_data", n), cdb_data, v.exp_data);
            checkOutput($sformatf("vec%0d_src", n), 32'(cdb_src), 32'(v.exp_src));
         end
      end

      // Reset mid-broadcast: pointer is 5 here, so requester 6 wins
      applyStimulus(7'h40, 1'b0, 4'hC, 32'h5000);
      checkOutput("rst_pre_grant", 32'(grant), 32'h40);
      @(posedge clk);
      #1;
      checkOutput("rst_pre_valid", 32'(cdb_valid), 32'd1);
      #2;
      reset = 1'b1;
      #1;
      checkOutput("rst_mid_valid", 32'(cdb_valid), 32'd0);
      checkOutput("rst_mid_tag", 32'(cdb_tag), 32'd0);
      checkOutput("rst_mid_data", cdb_data, 32'd0);
      checkOutput("rst_mid_src", 32'(cdb_src), 32'd0);
      checkOutput("rst_mid_grant", 32'(grant), 32'd0);
      @(negedge clk);
      reset     = 1'b0;
      req_valid = 7'h7F;
      #1;
      checkOutput("rst_post_grant", 32'(grant), 32'h01);

      // Randomized traffic against the reference model
      @(negedge clk);
      reset     = 1'b1;
      req_valid = '0;
      @(negedge clk);
      reset   = 1'b0;
      m_ptr   = 0;
      m_valid = 1'b0;
      m_tag   = '0;
      m_data  = '0;
      m_src   = 0;

      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
         req_valid = N_REQ'($urandom);
         cdb_stall = ($urandom_range(0, 7) == 0);
         for (int i = 0; i < N_REQ; i++) begin
            r_tags[i]  = TAG_W'($urandom);
            r_datas[i] = $urandom;
            req_tag[i*TAG_W +: TAG_W]    = r_tags[i];
            req_data[i*DATA_W +: DATA_W] = r_datas[i];
         end
         w = -1;
         if (!cdb_stall) begin
            for (int k = 0; k < N_REQ; k++) begin
               if (w < 0 && req_valid[(m_ptr + k) % N_REQ]) w = (m_ptr + k) % N_REQ;
            end
         end
         exp_g = '0;
         if (w >= 0) exp_g[w] = 1'b1;
         #1;
         checkOutput($sformatf("rnd%0d_grant", c), 32'(grant), 32'(exp_g));
         @(posedge clk);
         if (w >= 0) begin
            m_valid = 1'b1;
            m_tag   = r_tags[w];
            m_data  = r_datas[w];
            m_src   = w;
            m_ptr   = (w + 1) % N_REQ;
         end else begin
            m_valid = 1'b0;
         end
         #1;
         checkOutput($sformatf("rnd%0d_valid", c), 32'(cdb_valid), 32'(m_valid));
         checkOutput($sformatf("rnd%0d_tag", c), 32'(cdb_tag), 32'(m_tag));
         checkOutput($sformatf("rnd%0d_data", c), cdb_data, m_data);
         checkOutput($sformatf("rnd%0d_src", c), 32'(cdb_src), 32'(m_src));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
      $finish;
   end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Round-robin scheduler for the common data bus in the Tomasulo core. It collects completed results from every producer: three adders, two multipliers and two load read ports. Each cycle it grants exactly one producer and drives the registered CDB broadcast (valid, tag, data) that reservation stations, the register status table and the functional units snoop. Arbitration is fair: every requester that holds its request is granted within N_REQ cycles.

## Interface
Parameters:
- N_REQ, 7, number of requesters; index order is adder1..3 = 0..2, mul1..2 = 3..4, mem1..2 = 5..6.
- TAG_W, 4, width of a reservation-station tag.
- DATA_W, 32, width of the result data.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  N_REQ  bit i is high when requester i holds a result.
- req_tag  in  N_REQ*TAG_W  packed tags; requester i occupies [i*TAG_W +: TAG_W].
- req_data  in  N_REQ*DATA_W  packed results; requester i occupies [i*DATA_W +: DATA_W].
- cdb_stall  in  1  when high, suppresses all grants this cycle.
- grant  out  N_REQ  one-hot or zero; combinational in the cycle the request is accepted.
- cdb_valid  out  1  registered broadcast-valid signal.
- cdb_tag  out  TAG_W  registered broadcast tag.
- cdb_data  out  DATA_W  registered broadcast data.
- cdb_src  out  $clog2(N_REQ)  registered index of the requester being broadcast.

## Operation
- State: rr_ptr, $clog2(N_REQ) bits, giving the highest-priority index this cycle, plus the output register.
- Selection: scan indices rr_ptr, rr_ptr+1, … mod N_REQ. The first i with req_valid[i]=1 wins.
- grant[winner]=1 when there is a winner, cdb_stall=0 and reset=0. Otherwise grant is all zero.
- On a grant edge:
  - cdb_valid<=1, cdb_tag<=req_tag[winner], cdb_data<=req_data[winner], cdb_src<=winner.
  - rr_ptr<=(winner+1) mod N_REQ. Index N_REQ-1 wraps to 0.
- No grant (idle or stalled): cdb_valid<=0, while cdb_tag, cdb_data, cdb_src and rr_ptr hold their values.
- Requester contract:
  - Hold req_valid, tag and data stable until grant is seen.
  - Drop the request, or present the next result, in the cycle after the grant.
- The arbiter does not check tag value. Tag 0 ("no producer") is broadcast as given, and keeping tag 0 off the bus is the requester's responsibility.
- Fairness bound: a continuously requesting source waits at most N_REQ-1 granted cycles. Stalled cycles are not counted.

## Timing
- Reset, asynchronous and immediate: rr_ptr=0, cdb_valid=0, cdb_tag=0, cdb_data=0, cdb_src=0, grant=0.
- Latency: a request sampled at edge t is granted combinationally in cycle t and broadcast from cycle t+1, for exactly one cycle.
- Throughput: one broadcast per cycle. Back-to-back grants to different or the same requester are allowed.
- Simultaneous requests: only the winner is granted. Losers keep requesting and are re-evaluated next cycle against the updated rr_ptr.
- cdb_stall and a request in the same cycle: no grant, and the next cycle has cdb_valid=0.
- Reset asserted mid-broadcast: cdb_valid clears without a clock edge, and the pending grant is dropped. A requester that has not seen its grant must re-present after reset.
- No combinational path from req_* to cdb_* outputs. The only combinational path is req_valid/rr_ptr/cdb_stall to grant.

## Structure
- Shared package tomasulo_pkg holds:
  - TAG_W, DATA_W and N_REQ.
  - Source index constants SRC_ADD1..SRC_ADD3, SRC_MUL1, SRC_MUL2, SRC_MEM1, SRC_MEM2.
- Sub-module rr_pick is purely combinational:
  - Inputs: req vector and pointer.
  - Outputs: one-hot grant, winner index and any-valid.
  - Implemented as rotate, find-first, rotate back.
- cdb_arbiter holds rr_ptr, the output register and the tag/data mux.

## Test plan
- Reset: assert reset mid-cycle with cdb_valid=1 -> all outputs 0 immediately. After release, rr_ptr=0 is observable through the grant order.
- Single request: req_valid=7'b0000100, tag=4'h5, data=32'h0000_1234 -> grant=7'b0000100 in the same cycle. Next cycle cdb_valid=1, cdb_tag=5, cdb_data=0x1234, cdb_src=2. The cycle after, cdb_valid=0.
- Full load: all 7 requests held from rr_ptr=0 -> grants 0,1,2,3,4,5,6,0 on consecutive cycles, each followed by the matching broadcast with no bubbles.
- Wrap-around: drive rr_ptr to 6 (grant 5 first), then request indices 0 and 6 together -> 6 is granted, then 0.
- Stall: requests on 1 and 3 with cdb_stall=1 for 3 cycles -> grant=0, cdb_valid=0 and the pointer held. After release, 1 is broadcast, then 3.
- Producer handoff: requester 4 presents tag 4'h9 then tag 4'hA back-to-back, with no other requests -> two consecutive broadcasts, tags 9 then A, both with cdb_src=4.
